// File: rtl/fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// mips_defs -- definitions shared by the pipeline stages.
//   DEFAULT_RESET_PC  : first fetch address after reset
//   DEFAULT_NOP_INSTR : instruction word used for pipeline bubbles
//   fetchState_e      : fetch FSM state encodings
//   pcPlus4()         : 32-bit modulo PC increment
// ----------------------------------------------------------------------------
package mips_defs;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,  // ready to issue a request for PC
        FETCH_WAIT  = 2'd1,  // request granted, waiting for rvalid
        FETCH_HOLD  = 2'd2,  // word parked in skid while Decode is stalled
        FETCH_DRAIN = 2'd3   // request in flight belongs to a squashed path
    } fetchState_e;

    // Wraps naturally: 32'hFFFF_FFFC + 4 = 0.
    function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if -- instruction memory request/response bus.
//   imem_req    : fetch request (master -> slave)
//   imem_addr   : fetch address (master -> slave)
//   imem_gnt    : request accepted this cycle (slave -> master)
//   imem_rvalid : imem_rdata valid, at least one cycle after the grant
//   imem_rdata  : fetched instruction word
// ----------------------------------------------------------------------------
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// ----------------------------------------------------------------------------
// ifid_reg -- pipeline register with stall and flush, shared by IF/ID and
// ID/EX. Flush wins over stall; reset and flush load the same clear value.
//   clk, rst_n : clock, asynchronous active-low reset
//   stall      : hold current contents
//   flush      : load CLEAR_VAL (bubble)
//   d / q      : WIDTH-bit payload in / out
// ----------------------------------------------------------------------------
module ifid_reg #(
    parameter int               WIDTH     = 65,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= CLEAR_VAL;
        end else if (flush) begin
            q <= CLEAR_VAL;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage -- MIPS instruction fetch with one outstanding memory request.
//   clk, rst_n        : clock, asynchronous active-low reset
//   StallF, StallD    : hazard-unit stalls for Fetch and Decode
//   PCSrcD, JumpD     : taken branch / jump resolved in Decode
//   PCBranchD/PCJumpD : redirect targets
//   imem              : instruction memory bus (master side)
//   InstrD, PCPlus4D  : IF/ID payload
//   ValidD            : InstrD holds a real instruction
//   ImemStall         : Decode is starved (WAIT or DRAIN)
// ----------------------------------------------------------------------------
module fetch_stage
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 PCSrcD,
    input  logic                 JumpD,
    input  logic [31:0]          PCBranchD,
    input  logic [31:0]          PCJumpD,
    fetch_stage_if.master        imem,
    output logic [31:0]          InstrD,
    output logic [31:0]          PCPlus4D,
    output logic                 ValidD,
    output logic                 ImemStall
);

    localparam logic [64:0] IFID_CLEAR = {1'b0, 32'h0, NOP_INSTR};

    fetchState_e state;
    logic [31:0] pc;
    logic [31:0] skid;

    logic        redirect;
    logic [31:0] target;
    logic        granted;
    logic        deliverMem;
    logic        deliverSkid;
    logic [64:0] ifidD;
    logic [64:0] ifidQ;

    // Requests are gated by rst_n so the bus stays quiet while in reset.
    assign imem.imem_req  = (state == FETCH_REQ) && !StallF && rst_n;
    assign imem.imem_addr = pc;
    assign ImemStall      = (state == FETCH_WAIT) || (state == FETCH_DRAIN);

    // NOTE: every always_comb output gets a default value first, so no
    // path can leave a signal unassigned and infer a latch.
    always_comb begin
        redirect    = (PCSrcD || JumpD) && !StallD;
        target      = PCSrcD ? PCBranchD : PCJumpD;
        granted     = imem.imem_req && imem.imem_gnt;
        deliverMem  = (state == FETCH_WAIT) && imem.imem_rvalid && !StallD;
        deliverSkid = (state == FETCH_HOLD) && !StallD;
        ifidD       = IFID_CLEAR;
        if (deliverSkid) begin
            ifidD = {1'b1, pcPlus4(pc), skid};
        end else if (deliverMem) begin
            ifidD = {1'b1, pcPlus4(pc), imem.imem_rdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_REQ;
            pc    <= RESET_PC;
            skid  <= '0;
        end else begin
            unique case (state)
                FETCH_REQ: begin
                    // A redirect in the grant cycle orphans that request.
                    if (granted) state <= redirect ? FETCH_DRAIN : FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (redirect) begin
                        // If the stale word returns in the redirect cycle it
                        // is already gone, so there is nothing left to drain.
                        state <= imem.imem_rvalid ? FETCH_REQ : FETCH_DRAIN;
                    end else if (imem.imem_rvalid) begin
                        if (StallD) begin
                            skid  <= imem.imem_rdata;
                            state <= FETCH_HOLD;
                        end else begin
                            state <= FETCH_REQ;
                        end
                    end
                end
                FETCH_HOLD: begin
                    // Either the skid is delivered or a redirect discards it.
                    if (!StallD) begin
                        state <= FETCH_REQ;
                        skid  <= '0;
                    end
                end
                FETCH_DRAIN: begin
                    if (imem.imem_rvalid) state <= FETCH_REQ;
                end
                default: state <= FETCH_REQ;
            endcase

            if (redirect) begin
                pc <= target;
            end else if (deliverMem || deliverSkid) begin
                pc <= pcPlus4(pc);
            end
        end
    end

    ifid_reg #(
        .WIDTH     (65),
        .CLEAR_VAL (IFID_CLEAR)
    ) u_ifid (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (StallD),
        .flush (redirect),
        .d     (ifidD),
        .q     (ifidQ)
    );

    assign {ValidD, PCPlus4D, InstrD} = ifidQ;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage -- self-checking bench for fetch_stage. A cycle-level memory
// model answers requests; expected IF/ID contents are queued when the bench
// returns a word and compared when the delivery edge has passed.
// ----------------------------------------------------------------------------
module tb_fetch_stage;
    import mips_defs::*;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [64:0] BUBBLE = {1'b0, 32'h0, NOP};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF, StallD, PCSrcD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic [31:0] InstrD, PCPlus4D;
    logic        ValidD, ImemStall;

    fetch_stage_if imemBus();

    fetch_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .StallF    (StallF),
        .StallD    (StallD),
        .PCSrcD    (PCSrcD),
        .JumpD     (JumpD),
        .PCBranchD (PCBranchD),
        .PCJumpD   (PCJumpD),
        .imem      (imemBus),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .ImemStall (ImemStall)
    );

    always #5 clk = ~clk;

    int          testsRun = 0;
    int          testsFailed = 0;
    logic [64:0] expQ[$];
    logic [64:0] lastExp;
    logic        pendValid;
    logic [31:0] pendAddr;

    function automatic logic [31:0] wordFor(input logic [31:0] addr);
        return (addr == 32'h0) ? 32'h2008_0005 : (addr ^ 32'hC0DE_0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One memory cycle: return the pending word (if any), grant whatever is
    // requested. expectDeliver says the returned word must land in IF/ID.
    task automatic stepMem(input bit expectDeliver, input string tag);
        logic [64:0] exp;
        logic [64:0] obs;
        logic        granted;
        logic [31:0] grantAddr;
        imemBus.imem_rvalid = pendValid;
        imemBus.imem_rdata  = pendValid ? wordFor(pendAddr) : 32'h0;
        #1;
        imemBus.imem_gnt = imemBus.imem_req;
        granted   = imemBus.imem_req;
        grantAddr = imemBus.imem_addr;
        if (expectDeliver) expQ.push_back({1'b1, pendAddr + 32'd4, wordFor(pendAddr)});
        tick();
        imemBus.imem_gnt    = 1'b0;
        imemBus.imem_rvalid = 1'b0;
        pendValid = granted;
        pendAddr  = grantAddr;
        testsRun++;
        obs = {ValidD, PCPlus4D, InstrD};
        if (expectDeliver) begin
            if (expQ.size() == 0) begin
                $display("FAIL %s: scoreboard empty, got %h", tag, obs);
                testsFailed++;
            end else begin
                exp = expQ.pop_front();
                lastExp = exp;
                if (obs !== exp) begin
                    $display("FAIL %s: ifid got %h expected %h", tag, obs, exp);
                    testsFailed++;
                end
            end
        end else if (obs !== BUBBLE) begin
            $display("FAIL %s: bubble got %h expected %h", tag, obs, BUBBLE);
            testsFailed++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        StallF = 0; StallD = 0; PCSrcD = 0; JumpD = 0;
        PCBranchD = 0; PCJumpD = 0;
        imemBus.imem_gnt = 0; imemBus.imem_rvalid = 0; imemBus.imem_rdata = 0;
        pendValid = 0; pendAddr = 0;
        repeat (3) tick();
        testsRun++;
        if ({imemBus.imem_req, imemBus.imem_addr, ValidD, PCPlus4D, InstrD, ImemStall}
            !== {1'b0, 32'h0, BUBBLE, 1'b0}) begin
            $display("FAIL reset: req=%b addr=%h ifid=%h stall=%b expected 0/0/%h/0",
                     imemBus.imem_req, imemBus.imem_addr, {ValidD, PCPlus4D, InstrD},
                     ImemStall, BUBBLE);
            testsFailed++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_wait();
        #1;
        testsRun++;
        if ({imemBus.imem_req, imemBus.imem_addr} !== {1'b1, 32'h0}) begin
            $display("FAIL first_req: req=%b addr=%h expected 1/00000000",
                     imemBus.imem_req, imemBus.imem_addr);
            testsFailed++;
        end
        stepMem(1'b0, "first_grant");
        testsRun++;
        if (ImemStall !== 1'b1) begin
            $display("FAIL wait_stall: ImemStall=%b expected 1", ImemStall);
            testsFailed++;
        end
        stepMem(1'b1, "first_instr");
        for (int i = 0; i < 3; i++) begin
            stepMem(1'b0, "stream_bubble");
            stepMem(1'b1, "stream_instr");
        end
    endtask

    task automatic test_stall_skid();
        logic [31:0] addr;
        stepMem(1'b0, "skid_grant");
        addr = pendAddr;
        StallD = 1; StallF = 1;
        imemBus.imem_rvalid = 1; imemBus.imem_rdata = wordFor(addr);
        expQ.push_back({1'b1, addr + 32'd4, wordFor(addr)});
        pendValid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            imemBus.imem_rvalid = 0;
            testsRun++;
            if (dut.state !== FETCH_HOLD || {ValidD, PCPlus4D, InstrD} !== BUBBLE
                || imemBus.imem_addr !== addr || imemBus.imem_req !== 1'b0) begin
                $display("FAIL skid_hold: state=%0d ifid=%h addr=%h req=%b expected HOLD/%h/%h/0",
                         dut.state, {ValidD, PCPlus4D, InstrD}, imemBus.imem_addr,
                         imemBus.imem_req, BUBBLE, addr);
                testsFailed++;
            end
        end
        StallD = 0; StallF = 0;
        tick();
        lastExp = expQ.pop_front();
        testsRun++;
        if ({ValidD, PCPlus4D, InstrD} !== lastExp || imemBus.imem_addr !== addr + 32'd4
            || dut.state !== FETCH_REQ) begin
            $display("FAIL skid_release: ifid=%h addr=%h state=%0d expected %h/%h/REQ",
                     {ValidD, PCPlus4D, InstrD}, imemBus.imem_addr, dut.state,
                     lastExp, addr + 32'd4);
            testsFailed++;
        end
    endtask

    task automatic test_jump_drain();
        logic [31:0] oldAddr;
        stepMem(1'b0, "jump_grant");
        oldAddr = pendAddr;
        JumpD = 1; PCJumpD = 32'h0000_0040;
        tick();
        JumpD = 0;
        testsRun++;
        if (dut.state !== FETCH_DRAIN || ImemStall !== 1'b1 || imemBus.imem_addr !== 32'h40
            || ValidD !== 1'b0 || imemBus.imem_req !== 1'b0) begin
            $display("FAIL jump_drain: state=%0d stall=%b addr=%h valid=%b req=%b expected DRAIN/1/40/0/0",
                     dut.state, ImemStall, imemBus.imem_addr, ValidD, imemBus.imem_req);
            testsFailed++;
        end
        imemBus.imem_rvalid = 1; imemBus.imem_rdata = wordFor(oldAddr);
        pendValid = 0;
        tick();
        imemBus.imem_rvalid = 0;
        testsRun++;
        if ({ValidD, PCPlus4D, InstrD} !== BUBBLE || imemBus.imem_addr !== 32'h40
            || imemBus.imem_req !== 1'b1) begin
            $display("FAIL jump_discard: ifid=%h addr=%h req=%b expected %h/40/1",
                     {ValidD, PCPlus4D, InstrD}, imemBus.imem_addr, imemBus.imem_req, BUBBLE);
            testsFailed++;
        end
        stepMem(1'b0, "jump_target_grant");
        stepMem(1'b1, "jump_target_instr");
    endtask

    task automatic test_redirect_on_grant();
        JumpD = 1; PCJumpD = 32'h0000_0080;
        #1;
        imemBus.imem_gnt = imemBus.imem_req;
        tick();
        imemBus.imem_gnt = 0;
        JumpD = 0;
        testsRun++;
        if (dut.state !== FETCH_DRAIN || imemBus.imem_addr !== 32'h80 || ValidD !== 1'b0) begin
            $display("FAIL grant_redirect: state=%0d addr=%h valid=%b expected DRAIN/80/0",
                     dut.state, imemBus.imem_addr, ValidD);
            testsFailed++;
        end
        imemBus.imem_rvalid = 1; imemBus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        imemBus.imem_rvalid = 0;
        pendValid = 0;
        stepMem(1'b0, "grant_target_grant");
        stepMem(1'b1, "grant_target_instr");
    endtask

    task automatic test_branch_stalled();
        logic [31:0] addr;
        addr = imemBus.imem_addr;
        StallD = 1; StallF = 1; PCSrcD = 1; PCBranchD = 32'h0000_0100;
        repeat (2) begin
            tick();
            testsRun++;
            if (imemBus.imem_addr !== addr || {ValidD, PCPlus4D, InstrD} !== lastExp
                || imemBus.imem_req !== 1'b0) begin
                $display("FAIL branch_stalled: addr=%h ifid=%h req=%b expected %h/%h/0",
                         imemBus.imem_addr, {ValidD, PCPlus4D, InstrD}, imemBus.imem_req,
                         addr, lastExp);
                testsFailed++;
            end
        end
        StallD = 0; StallF = 0;
        tick();
        PCSrcD = 0;
        testsRun++;
        if (imemBus.imem_addr !== 32'h100 || ValidD !== 1'b0) begin
            $display("FAIL branch_taken: addr=%h valid=%b expected 100/0",
                     imemBus.imem_addr, ValidD);
            testsFailed++;
        end
        stepMem(1'b0, "branch_target_grant");
        stepMem(1'b1, "branch_target_instr");
    endtask

    task automatic test_wrap();
        JumpD = 1; PCJumpD = 32'hFFFF_FFFC;
        tick();
        JumpD = 0;
        stepMem(1'b0, "wrap_grant");
        stepMem(1'b1, "wrap_instr");
        testsRun++;
        if (imemBus.imem_addr !== 32'h0) begin
            $display("FAIL wrap_addr: addr=%h expected 00000000", imemBus.imem_addr);
            testsFailed++;
        end
    endtask

    task automatic test_reset_mid();
        JumpD = 1; PCJumpD = 32'h0000_0200;
        tick();
        JumpD = 0;
        stepMem(1'b0, "midreset_grant");
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (imemBus.imem_addr !== 32'h0 || ValidD !== 1'b0 || imemBus.imem_req !== 1'b0
            || dut.state !== FETCH_REQ) begin
            $display("FAIL midreset_async: addr=%h valid=%b req=%b state=%0d expected 0/0/0/REQ",
                     imemBus.imem_addr, ValidD, imemBus.imem_req, dut.state);
            testsFailed++;
        end
        tick();
        rst_n = 1'b1;
        pendValid = 0;
        imemBus.imem_rvalid = 1; imemBus.imem_rdata = wordFor(32'h200);
        tick();
        imemBus.imem_rvalid = 0;
        testsRun++;
        if (ValidD !== 1'b0 || imemBus.imem_addr !== 32'h0 || dut.state !== FETCH_REQ) begin
            $display("FAIL midreset_ignore: valid=%b addr=%h state=%0d expected 0/0/REQ",
                     ValidD, imemBus.imem_addr, dut.state);
            testsFailed++;
        end
        stepMem(1'b0, "midreset_refetch_grant");
        stepMem(1'b1, "midreset_refetch_instr");
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_skid();
        test_jump_drain();
        test_redirect_on_grant();
        test_branch_stalled();
        test_wrap();
        test_reset_mid();
        testsRun++;
        if (expQ.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left expected 0", expQ.size());
            testsFailed++;
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
